// File: rtl/attempt_lockout_ctrl.sv
// rtl/attempt_lockout_ctrl.sv - keypad passcode checker with consecutive-failure lockout
module attempt_lockout_ctrl #(
  parameter int                   DIGITS         = 6,
  parameter int                   MAX_FAIL       = 3,
  parameter int                   LOCKOUT_CYCLES = 24000000,
  parameter logic [4*DIGITS-1:0]  MASTER_CODE    = 24'h555116
) (
  input  logic                  hwclk,
  input  logic                  resetN,
  input  logic [3:0]            key,
  input  logic                  key_valid,
  input  logic [4*DIGITS-1:0]   user_code,
  output logic                  unlocked,
  output logic                  locked_out,
  output logic                  err_pulse,
  output logic [1:0]            fail_count,
  output logic [2:0]            digit_cnt,
  output logic [2:0]            state
);

  localparam int          TW         = $clog2(LOCKOUT_CYCLES) + 1;
  localparam logic [TW-1:0] TIMER_LOAD = TW'(LOCKOUT_CYCLES - 1);
  localparam logic [2:0]  DIGITS_C   = 3'(DIGITS);
  localparam logic [1:0]  MAX_FAIL_C = 2'(MAX_FAIL);
  localparam logic [3:0]  KEY_CLEAR  = 4'hA;
  localparam logic [3:0]  KEY_ENTER  = 4'hB;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ENTRY   = 3'd1,
    S_CHECK   = 3'd2,
    S_OPEN    = 3'd3,
    S_LOCKOUT = 3'd4
  } state_e;

  state_e                state_q;
  logic [4*DIGITS-1:0]   buf_q;
  logic [2:0]            cnt_q;
  logic [1:0]            fail_q;
  logic [TW-1:0]         timer_q;
  logic                  unlocked_q;
  logic                  locked_out_q;
  logic                  err_q;

  logic                  is_digit;
  logic                  match;
  logic [1:0]            fail_inc;

  assign is_digit = (key <= 4'd9);
  assign match    = (cnt_q == DIGITS_C) &&
                    ((buf_q == user_code) || (buf_q == MASTER_CODE));
  assign fail_inc = (fail_q >= MAX_FAIL_C) ? fail_q : fail_q + 2'd1;

  always_ff @(posedge hwclk) begin
    if (!resetN) begin
      state_q      <= S_IDLE;
      buf_q        <= '0;
      cnt_q        <= '0;
      fail_q       <= '0;
      timer_q      <= '0;
      unlocked_q   <= 1'b0;
      locked_out_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (key_valid && is_digit) begin
            buf_q   <= {{(4*DIGITS-4){1'b0}}, key};
            cnt_q   <= 3'd1;
            state_q <= S_ENTRY;
          end
        end
        S_ENTRY: begin
          if (key_valid) begin
            if (is_digit) begin
              if (cnt_q < DIGITS_C) begin
                buf_q <= {buf_q[4*DIGITS-5:0], key};
                cnt_q <= cnt_q + 3'd1;
              end
            end else if (key == KEY_CLEAR) begin
              buf_q   <= '0;
              cnt_q   <= '0;
              state_q <= S_IDLE;
            end else if (key == KEY_ENTER) begin
              state_q <= S_CHECK;
            end
          end
        end
        S_CHECK: begin
          // Single-cycle compare; key strobes arriving now are dropped.
          buf_q <= '0;
          cnt_q <= '0;
          if (match) begin
            fail_q     <= '0;
            unlocked_q <= 1'b1;
            state_q    <= S_OPEN;
          end else begin
            err_q  <= 1'b1;
            fail_q <= fail_inc;
            if (fail_inc == MAX_FAIL_C) begin
              timer_q      <= TIMER_LOAD;
              locked_out_q <= 1'b1;
              state_q      <= S_LOCKOUT;
            end else begin
              state_q <= S_IDLE;
            end
          end
        end
        S_OPEN: begin
          if (key_valid && (key == KEY_ENTER)) begin
            unlocked_q <= 1'b0;
            state_q    <= S_IDLE;
          end
        end
        S_LOCKOUT: begin
          if (timer_q == '0) begin
            fail_q       <= '0;
            locked_out_q <= 1'b0;
            state_q      <= S_IDLE;
          end else begin
            timer_q <= timer_q - 1'b1;
          end
        end
        default: begin
          buf_q        <= '0;
          cnt_q        <= '0;
          timer_q      <= '0;
          unlocked_q   <= 1'b0;
          locked_out_q <= 1'b0;
          state_q      <= S_IDLE;
        end
      endcase
    end
  end

  assign unlocked   = unlocked_q;
  assign locked_out = locked_out_q;
  assign err_pulse  = err_q;
  assign fail_count = fail_q;
  assign digit_cnt  = cnt_q;
  assign state      = state_q;

endmodule

// File: tb/tb_attempt_lockout_ctrl.sv
// tb/tb_attempt_lockout_ctrl.sv - directed self-checking bench for attempt_lockout_ctrl
module tb_attempt_lockout_ctrl;

  logic        hwclk = 1'b0;
  logic        resetN;
  logic [3:0]  key;
  logic        key_valid;
  logic [23:0] user_code;
  logic        unlocked;
  logic        locked_out;
  logic        err_pulse;
  logic [1:0]  fail_count;
  logic [2:0]  digit_cnt;
  logic [2:0]  state;

  int n_checks = 0;
  int n_pass   = 0;
  int lock_len;

  always #5 hwclk = ~hwclk;

  attempt_lockout_ctrl #(
    .DIGITS(6),
    .MAX_FAIL(3),
    .LOCKOUT_CYCLES(16),
    .MASTER_CODE(24'h555116)
  ) dut (
    .hwclk(hwclk),
    .resetN(resetN),
    .key(key),
    .key_valid(key_valid),
    .user_code(user_code),
    .unlocked(unlocked),
    .locked_out(locked_out),
    .err_pulse(err_pulse),
    .fail_count(fail_count),
    .digit_cnt(digit_cnt),
    .state(state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic press(input logic [3:0] k);
    @(negedge hwclk);
    key       = k;
    key_valid = 1'b1;
    @(negedge hwclk);
    key_valid = 1'b0;
  endtask

  task automatic press_n(input logic [3:0] k, input int n);
    for (int i = 0; i < n; i++) press(k);
  endtask

  task automatic wrong_entry(input int exp_fail);
    press(4'h1); press(4'h2); press(4'h3);
    press(4'hB);
    check("mis_check_state", state, 2);
    @(negedge hwclk);
    check("mis_err_pulse", err_pulse, 1);
    check("mis_fail_count", fail_count, exp_fail);
  endtask

  initial begin
    resetN    = 1'b0;
    key       = 4'h5;
    key_valid = 1'b1;
    user_code = 24'h666666;
    repeat (3) @(negedge hwclk);
    check("rst_state", state, 0);
    check("rst_digit_cnt", digit_cnt, 0);
    check("rst_outputs", {unlocked, locked_out, err_pulse, fail_count}, 0);
    resetN    = 1'b1;
    key_valid = 1'b0;
    @(negedge hwclk);
    check("rst_strobe_discarded", state, 0);

    // user code match
    press_n(4'h6, 6);
    check("user_digit_cnt", digit_cnt, 6);
    check("user_entry_state", state, 1);
    press(4'hB);
    check("user_check_state", state, 2);
    @(negedge hwclk);
    check("user_unlocked", unlocked, 1);
    check("user_open_state", state, 3);
    check("user_fail_zero", fail_count, 0);
    check("user_buf_cleared", digit_cnt, 0);
    press(4'h6);
    check("open_ignores_digit", {state, unlocked}, {3'd3, 1'b1});
    press(4'hB);
    check("relock_state", state, 0);
    check("relock_unlocked", unlocked, 0);

    // master code match, key C strobed during CHECK
    press(4'h5); press(4'h5); press(4'h5);
    press(4'h1); press(4'h1); press(4'h6);
    press(4'hB);
    key       = 4'hC;
    key_valid = 1'b1;
    @(negedge hwclk);
    key_valid = 1'b0;
    check("master_unlocked", unlocked, 1);
    check("master_state", state, 3);
    check("check_keyC_digit_cnt", digit_cnt, 0);
    press(4'hB);
    check("master_relock", {state, unlocked}, {3'd0, 1'b0});

    // clear keeps fail count; seventh digit dropped
    wrong_entry(1);
    check("mis1_state", state, 0);
    press_n(4'h6, 3);
    check("pre_clear_cnt", digit_cnt, 3);
    press(4'hA);
    check("clear_state", state, 0);
    check("clear_digit_cnt", digit_cnt, 0);
    check("clear_keeps_fail", fail_count, 1);
    press_n(4'h6, 7);
    check("seventh_dropped", digit_cnt, 6);
    press(4'hB);
    @(negedge hwclk);
    check("after_clear_unlocked", unlocked, 1);
    check("after_clear_fail_zero", fail_count, 0);
    press(4'hB);

    // three mismatches -> lockout of exactly 16 cycles; digit in CHECK ignored
    press(4'h1); press(4'h2); press(4'h3);
    press(4'hB);
    key       = 4'h7;
    key_valid = 1'b1;
    @(negedge hwclk);
    key_valid = 1'b0;
    check("err1_pulse", err_pulse, 1);
    check("err1_fail", fail_count, 1);
    check("check_digit_ignored", {state, digit_cnt}, {3'd0, 3'd0});
    @(negedge hwclk);
    check("err_pulse_one_cycle", err_pulse, 0);
    wrong_entry(2);
    wrong_entry(3);
    check("lock_state", state, 4);
    check("lock_flag", locked_out, 1);
    lock_len = 0;
    while (locked_out && lock_len < 100) begin
      lock_len++;
      key       = 4'h6;
      key_valid = 1'b1;
      @(negedge hwclk);
    end
    key_valid = 1'b0;
    check("lock_length", lock_len, 16);
    check("post_lock_state", state, 0);
    check("post_lock_fail", fail_count, 0);
    check("lock_digits_ignored", digit_cnt, 0);

    // reset during lockout
    wrong_entry(1);
    wrong_entry(2);
    wrong_entry(3);
    repeat (4) @(negedge hwclk);
    check("rst_lock_active", locked_out, 1);
    resetN = 1'b0;
    @(negedge hwclk);
    resetN = 1'b1;
    check("rst_lock_flag", locked_out, 0);
    check("rst_lock_state", state, 0);
    check("rst_lock_fail", fail_count, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
